// File: rtl/reglk_access_guard.sv
// Register-lock access guard: forwards bus reads, forwards writes only when the
// target lock bit is clear, and logs blocked or out-of-range accesses.
module reglk_access_guard #(
    parameter int unsigned NUM_WORDS = 6,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_WORDS*32-1:0] reglk_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   dn_valid_o,
    input  logic                   dn_ready_i,
    output logic                   dn_we_o,
    output logic [ADDR_W-1:0]      dn_addr_o,
    output logic [31:0]            dn_wdata_o,
    output logic                   rsp_valid_o,
    output logic                   rsp_err_o,
    input  logic                   viol_clr_i,
    output logic [CNT_W-1:0]       viol_count_o,
    output logic [ADDR_W-1:0]      viol_addr_o,
    output logic                   viol_irq_o
);

    localparam int unsigned NUM_REGS = NUM_WORDS * 32;
    localparam int unsigned IDX_W    = ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FWD,
        ST_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic             oor;
    logic             locked;
    logic             block;

    // Lock lookup on the captured address; out-of-range indices never match.
    always_comb begin
        idx    = dn_addr_o[ADDR_W-1:2];
        locked = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                locked = reglk_i[i];
            end
        end
        oor   = (32'(idx) >= NUM_REGS);
        block = oor | (dn_we_o & locked);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid_i) state_d = ST_CHECK;
            ST_CHECK: state_d = block ? ST_RESP : ST_FWD;
            ST_FWD:   if (dn_ready_i) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_o <= 1'b1;
            dn_valid_o  <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            dn_we_o     <= 1'b0;
            dn_addr_o   <= '0;
            dn_wdata_o  <= '0;
        end else begin
            req_ready_o <= (state_d == ST_IDLE);
            dn_valid_o  <= (state_d == ST_FWD);
            rsp_valid_o <= (state_d == ST_RESP);
            rsp_err_o   <= (state_q == ST_CHECK) && block;
            if (state_q == ST_IDLE && req_valid_i) begin
                dn_we_o    <= req_we_i;
                dn_addr_o  <= req_addr_i;
                dn_wdata_o <= req_wdata_i;
            end
        end
    end

    // Violation log; a new violation takes priority over a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            viol_count_o <= '0;
            viol_addr_o  <= '0;
            viol_irq_o   <= 1'b0;
        end else if (state_q == ST_CHECK && block) begin
            if (viol_clr_i) begin
                viol_count_o <= CNT_W'(1);
            end else if (viol_count_o != {CNT_W{1'b1}}) begin
                viol_count_o <= viol_count_o + CNT_W'(1);
            end
            viol_addr_o <= dn_addr_o;
            viol_irq_o  <= 1'b1;
        end else if (viol_clr_i) begin
            viol_count_o <= '0;
            viol_irq_o   <= 1'b0;
        end
    end

endmodule
